// File: rtl/lsu_store_buffer.sv
// Store queue between the LSU and a single-port data RAM: loads win the port and
// forward from the youngest matching queued store; stores drain in order when idle.
module lsu_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              sb_full,
  output logic              sb_empty,
  output logic              overflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_valid;
  logic [PTR_W-1:0]  head, tail, idx;
  logic [PTR_W:0]    count;

  logic              drain, push, drop;
  logic              fwd_hit_c, fwd_hit, rd_pending;
  logic [DATA_W-1:0] fwd_data_c, fwd_data, rd_hold;

  always_comb begin
    drain = !rd_en && (count != '0);
    push  = wr_en && ((count < FULL_CNT) || drain);
    drop  = wr_en && !push;
  end

  // Walk oldest to youngest so the last hit is the entry nearest the tail.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (q_valid[idx] && (q_addr[idx][ADDR_W-1:2] == rd_addr[ADDR_W-1:2])) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = q_data[idx];
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (rd_en) begin
        mem_re   = 1'b1;
        mem_addr = rd_addr;
      end else if (count != '0) begin
        mem_we    = 1'b1;
        mem_addr  = q_addr[head];
        mem_wdata = q_data[head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= wr_addr;
      q_data[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      q_valid    <= '0;
      overflow   <= 1'b0;
      rd_pending <= 1'b0;
      fwd_hit    <= 1'b0;
      fwd_data   <= '0;
      rd_hold    <= '0;
    end else begin
      // Clear before set: when full with push+pop, head==tail and the slot stays valid.
      if (drain) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        q_valid[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow   <= drop;
      rd_pending <= rd_en;
      fwd_hit    <= fwd_hit_c;
      fwd_data   <= fwd_data_c;
      if (rd_pending) rd_hold <= rd_data;
    end
  end

  always_comb begin
    if (rd_pending) rd_data = fwd_hit ? fwd_data : mem_rdata;
    else            rd_data = rd_hold;
  end

  assign sb_full  = (count == FULL_CNT);
  assign sb_empty = (count == '0);

endmodule
